load_align_unit: RTL

- Parametrised load-data alignment unit between the memory-access stage and a synchronous single-port data SRAM with 1-cycle read latency.
- Accepts one load request per cycle and issues word-aligned SRAM reads.
- Extracts and sign/zero-extends the addressed bytes.
- Splits word-crossing (misaligned) loads into two back-to-back reads, stalling upstream for the extra cycle.

---
 rtl/load_align_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load-data alignment unit for a 1-cycle-latency data SRAM.
// Define LOAD_ALIGN_MISALIGN_TRAP_EN to trap word-crossing loads instead of splitting them.
module load_align_unit #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          cpurst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_opmode,
    input  logic          flush,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          load_stall
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_BEAT1} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_BEAT1, S_BEAT2} state_t;
`endif

    function automatic logic [3:0] op_bytes(input logic [2:0] op);
        case (op[1:0])
            2'd0:    op_bytes = 4'd1;
            2'd1:    op_bytes = 4'd2;
            2'd2:    op_bytes = 4'd4;
            default: op_bytes = 4'd8;
        endcase
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        op_illegal = (op == 3'b111) || ((DW == 32) && ((op == 3'b011) || (op == 3'b110)));
    endfunction

    state_t          state_q;
    logic [2:0]      op_q;
    logic [OW-1:0]   off_q;
    logic [AW-1:0]   base_q;
    logic            ill_q;
    logic            cross_q;
    logic [DW-1:0]   data_q;
`ifndef LOAD_ALIGN_MISALIGN_TRAP_EN
    logic [DW-1:0]   lo_q;
`endif

    logic [OW-1:0]   req_off;
    logic [AW-1:0]   req_base;
    logic            req_ill;
    logic            req_cross;

    assign req_off   = req_addr[OW-1:0];
    assign req_base  = {req_addr[AW-1:OW], {OW{1'b0}}};
    assign req_ill   = op_illegal(req_opmode);
    assign req_cross = (5'(req_off) + 5'(op_bytes(req_opmode))) > 5'(NB);

    logic            rdy;
    logic            stall;
    logic            rv;
    logic            err;
    logic            second;
    logic            accept;
    logic            en;
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] win;

    always_comb begin
        rdy    = 1'b0;
        stall  = 1'b0;
        rv     = 1'b0;
        err    = 1'b0;
        second = 1'b0;
        win    = {{DW{1'b0}}, mem_rdata};
        case (state_q)
            S_IDLE: begin
                rdy = ~flush;
            end
            S_BEAT1: begin
                if (ill_q) begin
                    rv  = ~flush;
                    err = 1'b1;
                    rdy = ~flush;
                end else if (cross_q) begin
`ifdef LOAD_ALIGN_MISALIGN_TRAP_EN
                    rv  = ~flush;
                    err = 1'b1;
                    rdy = ~flush;
`else
                    second = ~flush;
                    stall  = ~flush;
`endif
                end else begin
                    rv  = ~flush;
                    rdy = ~flush;
                end
            end
`ifndef LOAD_ALIGN_MISALIGN_TRAP_EN
            S_BEAT2: begin
                rv  = ~flush;
                rdy = ~flush;
                win = {mem_rdata, lo_q};
            end
`endif
            default: ;
        endcase
    end

    // The first read of a new load and the second beat of a split never coincide,
    // because req_ready is low while the second beat is issued.
    always_comb begin
        accept = req_valid & rdy;
        en     = 1'b0;
        addr   = '0;
        if (accept && !req_ill) begin
            en   = 1'b1;
            addr = req_base;
        end else if (second) begin
            en   = 1'b1;
            addr = base_q + AW'(NB);
        end
    end

    logic [6:0]      kept_bits;
    logic [DW-1:0]   kept_mask;
    logic [2*DW-1:0] win_sh;
    logic [DW-1:0]   sh_lo;
    logic            top_bit;
    logic [DW-1:0]   ext_data;

    always_comb begin
        kept_bits = {op_bytes(op_q), 3'b000};
        kept_mask = {DW{1'b1}} >> (7'(DW) - kept_bits);
        win_sh    = win >> {off_q, 3'b000};
        sh_lo     = win_sh[DW-1:0];
        // Highest kept bit is the single bit set in mask but not in mask>>1.
        top_bit   = |(sh_lo & kept_mask & ~(kept_mask >> 1));
        ext_data  = (sh_lo & kept_mask) | ((~op_q[2] & top_bit) ? ~kept_mask : {DW{1'b0}});
        if (err) begin
            ext_data = '0;
        end
    end

    assign req_ready  = rdy | ~cpurst_n;
    assign mem_en     = en & cpurst_n;
    assign mem_addr   = cpurst_n ? addr : '0;
    assign rsp_valid  = rv & cpurst_n;
    assign rsp_err    = err & rv & cpurst_n;
    assign load_stall = stall & cpurst_n;
    assign rsp_data   = rsp_valid ? ext_data : data_q;

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            off_q   <= '0;
            base_q  <= '0;
            ill_q   <= 1'b0;
            cross_q <= 1'b0;
            data_q  <= '0;
`ifndef LOAD_ALIGN_MISALIGN_TRAP_EN
            lo_q    <= '0;
`endif
        end else begin
            if (rsp_valid) begin
                data_q <= ext_data;
            end
`ifndef LOAD_ALIGN_MISALIGN_TRAP_EN
            if (second) begin
                lo_q <= mem_rdata;
            end
`endif
            if (accept) begin
                state_q <= S_BEAT1;
                op_q    <= req_opmode;
                off_q   <= req_off;
                base_q  <= req_base;
                ill_q   <= req_ill;
                cross_q <= req_cross & ~req_ill;
            end
`ifndef LOAD_ALIGN_MISALIGN_TRAP_EN
            else if (second) begin
                state_q <= S_BEAT2;
            end
`endif
            else begin
                state_q <= S_IDLE;
            end
        end
    end

endmodule
